// File: rtl/ram_dp_clr.sv
// ram_dp_clr: shared-array RAM with one read/write port (A, CPU side) and one
// read-only port (B, debug/DMA side). Port A supports byte-lane write enables
// and a selectable read-during-write result. After reset a clear engine fills
// every word with INIT_VAL, one word per cycle, while busy is high.
//
// Handshake: port B is a fire-and-forget request. b_en=1 on an edge (outside
// CLEAR) is a request; exactly one cycle later b_valid pulses for one cycle
// with b_q carrying the data. There is no back-pressure, so a request can be
// issued every cycle. Requests made while busy=1 are dropped and produce no
// b_valid.
module ram_dp_clr #(
  parameter int                 DWIDTH   = 16,
  parameter int                 AWIDTH   = 12,
  parameter int                 WORDS    = 4096,
  parameter bit                 RDW_NEW  = 1'b0,
  parameter bit                 CLEAR_EN = 1'b1,
  parameter logic [DWIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     d,
  input  logic [DWIDTH/8-1:0]   be,
  output logic [DWIDTH-1:0]     q,
  input  logic                  b_en,
  input  logic [AWIDTH-1:0]     b_addr,
  output logic [DWIDTH-1:0]     b_q,
  output logic                  b_valid,
  output logic                  busy
);

  localparam int LANES = DWIDTH / 8;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t                state;
  state_t                state_nxt;

  logic [DWIDTH-1:0]     mem [WORDS];
  logic [IW-1:0]         ptr;
  logic                  clear_last;

  logic                  a_ok;
  logic                  b_ok;
  logic [IW-1:0]         a_idx;
  logic [IW-1:0]         b_idx;
  logic                  wr_en;
  logic [DWIDTH-1:0]     a_word;
  logic [DWIDTH-1:0]     b_word;
  logic [DWIDTH-1:0]     merge_word;

  // Addresses at or beyond WORDS are outside the array: writes dropped, reads 0.
  assign a_ok  = ({1'b0, addr}   < (AWIDTH+1)'(WORDS));
  assign b_ok  = ({1'b0, b_addr} < (AWIDTH+1)'(WORDS));
  assign a_idx = addr[IW-1:0];
  assign b_idx = b_addr[IW-1:0];

  assign clear_last = (ptr == IW'(WORDS - 1));
  assign busy       = (state == CLEAR);
  assign wr_en      = (state == IDLE) && load && a_ok;

  // Pre-write words seen by both ports this cycle
  always_comb begin
    a_word = '0;
    b_word = '0;
    if (a_ok) a_word = mem[a_idx];
    if (b_ok) b_word = mem[b_idx];
  end

  // Port-A word as it will look after this cycle's byte-lane write
  always_comb begin
    merge_word = a_word;
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && be[i]) merge_word[8*i +: 8] = d[8*i +: 8];
    end
  end

  // State register; reset picks the clear engine or goes straight to IDLE
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR_EN ? CLEAR : IDLE;
    else     state <= state_nxt;
  end

  // Next state: CLEAR leaves on the edge that writes the last word
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clear_last) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear pointer walks the array once per clear run
  always_ff @(posedge clk) begin
    if (rst)                  ptr <= '0;
    else if (state == CLEAR)  ptr <= clear_last ? '0 : ptr + 1'b1;
  end

  // Array writes: clear engine fill, or port-A byte-lane write; rst edge writes nothing
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= INIT_VAL;
      end else if (wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[a_idx][8*i +: 8] <= d[8*i +: 8];
        end
      end
    end
  end

  // Port A registered read, every cycle in IDLE; zero while clearing
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) q <= '0;
    else                       q <= RDW_NEW ? merge_word : a_word;
  end

  // Port B registered read; b_q always gets the pre-write word on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      b_valid <= 1'b0;
    end else if (state == IDLE && b_en) begin
      b_q     <= b_word;
      b_valid <= 1'b1;
    end else begin
      b_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr. Three instances share one stimulus bus:
//   dut0: RDW_NEW=0, CLEAR_EN=1, AWIDTH=4  (port-B scoreboard target)
//   dut1: RDW_NEW=1, CLEAR_EN=1, AWIDTH=4
//   dut2: RDW_NEW=0, CLEAR_EN=0, AWIDTH=5  (reaches addresses >= WORDS)
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_ram_dp_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [4:0]  addr;
  logic [15:0] d;
  logic [1:0]  be;
  logic        b_en;
  logic [4:0]  b_addr;

  logic [15:0] q0, q1, q2, b_q0, b_q1, b_q2;
  logic        b_valid0, b_valid1, b_valid2;
  logic        busy0, busy1, busy2;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ram_dp_clr #(.DWIDTH(16), .AWIDTH(4), .WORDS(16), .RDW_NEW(1'b0), .CLEAR_EN(1'b1),
               .INIT_VAL(16'hA5A5)) dut0 (
    .clk(clk), .rst(rst), .load(load), .addr(addr[3:0]), .d(d), .be(be), .q(q0),
    .b_en(b_en), .b_addr(b_addr[3:0]), .b_q(b_q0), .b_valid(b_valid0), .busy(busy0));

  ram_dp_clr #(.DWIDTH(16), .AWIDTH(4), .WORDS(16), .RDW_NEW(1'b1), .CLEAR_EN(1'b1),
               .INIT_VAL(16'hA5A5)) dut1 (
    .clk(clk), .rst(rst), .load(load), .addr(addr[3:0]), .d(d), .be(be), .q(q1),
    .b_en(b_en), .b_addr(b_addr[3:0]), .b_q(b_q1), .b_valid(b_valid1), .busy(busy1));

  ram_dp_clr #(.DWIDTH(16), .AWIDTH(5), .WORDS(16), .RDW_NEW(1'b0), .CLEAR_EN(1'b0),
               .INIT_VAL(16'hA5A5)) dut2 (
    .clk(clk), .rst(rst), .load(load), .addr(addr), .d(d), .be(be), .q(q2),
    .b_en(b_en), .b_addr(b_addr), .b_q(b_q2), .b_valid(b_valid2), .busy(busy2));

  // Scoreboard: every dut0 b_valid pops one expected word
  always @(negedge clk) begin
    logic [15:0] e;
    if (b_valid0 === 1'b1) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL b_port_unexpected: b_valid=1 b_q=%h, nothing expected", b_q0);
      end else begin
        e = exp_q.pop_front();
        if (b_q0 !== e) $display("FAIL b_port_data: got %h expected %h", b_q0, e);
        else            pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load = 1'b0; addr = '0; d = '0; be = '0; b_en = 1'b0; b_addr = '0;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rst = 1'b1;
    tick();
    check_cnt++; if (busy0 !== 1'b1)   $display("FAIL reset_busy: got %b expected 1", busy0);    else pass_cnt++;
    check_cnt++; if (q0 !== 16'h0)     $display("FAIL reset_q: got %h expected 0000", q0);       else pass_cnt++;
    check_cnt++; if (b_q0 !== 16'h0)   $display("FAIL reset_b_q: got %h expected 0000", b_q0);   else pass_cnt++;
    check_cnt++; if (b_valid0 !== 1'b0) $display("FAIL reset_b_valid: got %b expected 0", b_valid0); else pass_cnt++;
    check_cnt++; if (busy2 !== 1'b0)   $display("FAIL reset_busy_noclear: got %b expected 0", busy2); else pass_cnt++;
    rst = 1'b0;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check_cnt++; if (cnt != 16) $display("FAIL clear_length: got %0d cycles expected 16", cnt); else pass_cnt++;
    check_cnt++; if (busy1 !== 1'b0) $display("FAIL clear_done_dut1: busy got %b expected 0", busy1); else pass_cnt++;
  endtask

  task automatic test_clear_read();
    for (int i = 0; i < 16; i++) begin
      b_en = 1'b1; b_addr = 5'(i);
      exp_q.push_back(16'hA5A5);
      tick();
    end
    b_en = 1'b0;
    tick(); tick();
    check_cnt++; if (exp_q.size() != 0) $display("FAIL clear_read_drain: %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    load = 1'b1; addr = 5'd3; d = 16'h1234; be = 2'b11; tick();
    load = 1'b1; addr = 5'd3; d = 16'hABCD; be = 2'b10; tick();
    check_cnt++; if (q0 !== 16'h1234) $display("FAIL lanes_old_q: got %h expected 1234", q0); else pass_cnt++;
    check_cnt++; if (q1 !== 16'hAB34) $display("FAIL lanes_new_q: got %h expected AB34", q1); else pass_cnt++;
    load = 1'b1; addr = 5'd3; d = 16'hFFFF; be = 2'b00; tick();
    check_cnt++; if (q0 !== 16'hAB34) $display("FAIL lanes_merge: got %h expected AB34", q0); else pass_cnt++;
    check_cnt++; if (q1 !== 16'hAB34) $display("FAIL lanes_be0_new: got %h expected AB34", q1); else pass_cnt++;
    load = 1'b1; addr = 5'd3; d = 16'h0077; be = 2'b01; tick();
    check_cnt++; if (q0 !== 16'hAB34) $display("FAIL lanes_be0_nowrite: got %h expected AB34", q0); else pass_cnt++;
    load = 1'b0; tick();
    check_cnt++; if (q0 !== 16'hAB77) $display("FAIL lanes_low: got %h expected AB77", q0); else pass_cnt++;
  endtask

  task automatic test_rdw();
    load = 1'b1; addr = 5'd5; d = 16'h1111; be = 2'b11; tick();
    load = 1'b1; addr = 5'd5; d = 16'h2222; be = 2'b11; tick();
    check_cnt++; if (q0 !== 16'h1111) $display("FAIL rdw_old: got %h expected 1111", q0); else pass_cnt++;
    check_cnt++; if (q1 !== 16'h2222) $display("FAIL rdw_new: got %h expected 2222", q1); else pass_cnt++;
    load = 1'b0; tick();
    check_cnt++; if (q0 !== 16'h2222) $display("FAIL rdw_old_after: got %h expected 2222", q0); else pass_cnt++;
    check_cnt++; if (q1 !== 16'h2222) $display("FAIL rdw_new_after: got %h expected 2222", q1); else pass_cnt++;
  endtask

  task automatic test_collision();
    load = 1'b1; addr = 5'd7; d = 16'h00FF; be = 2'b11; tick();
    load = 1'b1; addr = 5'd7; d = 16'hFF00; be = 2'b11;
    b_en = 1'b1; b_addr = 5'd7; exp_q.push_back(16'h00FF); tick();
    load = 1'b0;
    b_en = 1'b1; b_addr = 5'd7; exp_q.push_back(16'hFF00); tick();
    b_en = 1'b0; tick(); tick();
    check_cnt++; if (exp_q.size() != 0) $display("FAIL collision_drain: %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int cnt;
    idle_inputs();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    load = 1'b1; addr = 5'd9; d = 16'h1234; be = 2'b11;
    b_en = 1'b1; b_addr = 5'd9;
    tick();
    check_cnt++; if (busy0 !== 1'b1) $display("FAIL restart_busy: got %b expected 1", busy0); else pass_cnt++;
    check_cnt++; if (q0 !== 16'h0)   $display("FAIL restart_q: got %h expected 0000", q0);   else pass_cnt++;
    rst = 1'b0;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    load = 1'b0; b_en = 1'b0;
    check_cnt++; if (cnt != 16) $display("FAIL restart_length: got %0d cycles expected 16", cnt); else pass_cnt++;
    b_en = 1'b1; b_addr = 5'd9; exp_q.push_back(16'hA5A5); tick();
    b_en = 1'b0; tick(); tick();
    check_cnt++; if (exp_q.size() != 0) $display("FAIL busy_drain: %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] m [16];
    logic [15:0] exp_a;
    logic [3:0]  a4, b4;
    for (int i = 0; i < 16; i++) m[i] = 16'hA5A5;
    exp_a = 16'h0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        check_cnt++;
        if (q0 !== exp_a) $display("FAIL b2b_q cycle %0d: got %h expected %h", n, q0, exp_a);
        else pass_cnt++;
      end
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      load = 1'($urandom_range(0, 1));
      be   = 2'($urandom_range(0, 3));
      d    = 16'($urandom_range(0, 65535));
      b_en = ($urandom_range(0, 3) != 0);
      addr = {1'b0, a4}; b_addr = {1'b0, b4};
      exp_a = m[a4];
      if (b_en) exp_q.push_back(m[b4]);
      if (load) begin
        if (be[0]) m[a4][7:0]  = d[7:0];
        if (be[1]) m[a4][15:8] = d[15:8];
      end
      tick();
    end
    check_cnt++;
    if (q0 !== exp_a) $display("FAIL b2b_q last: got %h expected %h", q0, exp_a); else pass_cnt++;
    idle_inputs(); tick(); tick();
    check_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_noclear_oor();
    idle_inputs();
    load = 1'b1; addr = 5'd2; d = 16'hBEEF; be = 2'b11; tick();
    load = 1'b0; rst = 1'b1; tick();
    check_cnt++; if (busy2 !== 1'b0) $display("FAIL noclear_busy: got %b expected 0", busy2); else pass_cnt++;
    check_cnt++; if (q2 !== 16'h0)   $display("FAIL noclear_q_reset: got %h expected 0000", q2); else pass_cnt++;
    rst = 1'b0; addr = 5'd2; tick();
    check_cnt++; if (q2 !== 16'hBEEF) $display("FAIL noclear_keep: got %h expected BEEF", q2); else pass_cnt++;
    check_cnt++; if (busy2 !== 1'b0)  $display("FAIL noclear_busy_after: got %b expected 0", busy2); else pass_cnt++;
    // dut0/dut1 are clearing here, so their port-B requests are dropped
    load = 1'b1; addr = 5'd18; d = 16'h1357; be = 2'b11; tick();
    load = 1'b0; addr = 5'd18; tick();
    check_cnt++; if (q2 !== 16'h0) $display("FAIL oor_read_q: got %h expected 0000", q2); else pass_cnt++;
    addr = 5'd2; b_en = 1'b1; b_addr = 5'd18; tick();
    check_cnt++; if (q2 !== 16'hBEEF) $display("FAIL oor_no_alias: got %h expected BEEF", q2); else pass_cnt++;
    check_cnt++; if (b_valid2 !== 1'b1) $display("FAIL oor_b_valid: got %b expected 1", b_valid2); else pass_cnt++;
    check_cnt++; if (b_q2 !== 16'h0) $display("FAIL oor_b_q: got %h expected 0000", b_q2); else pass_cnt++;
    b_en = 1'b0; tick();
    check_cnt++; if (b_valid2 !== 1'b0) $display("FAIL b_valid_pulse: got %b expected 0", b_valid2); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_clear_read();
    test_byte_lanes();
    test_rdw();
    test_collision();
    test_busy_ignore();
    test_back_to_back();
    test_noclear_oor();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

endmodule
